// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory byte loader and the memory write-port model.
package instr_mem_loader_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] RECV  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int DATA_WIDTH_DFLT = 32;
  localparam int BPW             = DATA_WIDTH_DFLT / 8;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Big-endian byte packer: the first byte shifted in ends up in the top byte of the word.
module word_assembler #(
  parameter int data_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic [7:0]            byte_data,
  input  logic                  clr,
  output logic [data_WIDTH-1:0] word,
  output logic                  full
);
  import instr_mem_loader_pkg::*;

  localparam int WB = bytes_per_word(data_WIDTH);
  localparam int CW = $clog2(WB) + 1;

  logic [CW-1:0] cnt;

  // Combinational: this shift completes the word, so the FSM can leave RECV on the same edge.
  assign full = shift_en && (cnt == CW'(WB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (shift_en) begin
      cnt  <= cnt + 1'b1;
      word <= data_WIDTH'({word, byte_data});
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Fills instruction memory from a host byte stream, one write per packed word at consecutive addresses.
module instr_mem_loader #(
  parameter int data_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   n_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [data_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  import instr_mem_loader_pkg::*;

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [2:0]            state;
  logic [ADDR_WIDTH:0]   n_q;
  logic [ADDR_WIDTH:0]   word_idx;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [data_WIDTH-1:0] data_q;
  logic [data_WIDTH-1:0] asm_word;
  logic                  asm_full;
  logic                  xfer;
  logic                  start_ok;

  assign byte_ready = (state == RECV);
  assign xfer       = byte_valid & byte_ready;
  assign start_ok   = start & ((state == IDLE) | (state == DONE));
  assign mem_we     = (state == WRITE);
  assign busy       = (state == CHECK) | (state == RECV) | (state == WRITE);
  assign done       = (state == DONE);
  assign err        = err_q;

  // During WRITE the live word/index drive the port; afterwards the captured copies hold it.
  assign mem_addr = mem_we ? word_idx[ADDR_WIDTH-1:0] : addr_q;
  assign mem_data = mem_we ? asm_word : data_q;

  word_assembler #(.data_WIDTH(data_WIDTH)) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (xfer),
    .byte_data (byte_data),
    .clr       (start_ok | mem_we),
    .word      (asm_word),
    .full      (asm_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      n_q      <= '0;
      word_idx <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            n_q      <= n_words;
            word_idx <= '0;
            err_q    <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (n_q == '0) begin
            state <= DONE;
          end else if (n_q > MAX_WORDS) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            state <= RECV;
          end
        end
        RECV: begin
          if (asm_full) state <= WRITE;
        end
        WRITE: begin
          addr_q   <= word_idx[ADDR_WIDTH-1:0];
          data_q   <= asm_word;
          word_idx <= word_idx + 1'b1;
          // Full ADDR_WIDTH+1-bit compare so a 2**ADDR_WIDTH-word load terminates without wrapping.
          state    <= ((word_idx + 1'b1) == n_q) ? DONE : RECV;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: vector table plus hand sequences for reset, restart and full-memory loads.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] n_words = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, mem_we, busy, done, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;

  instr_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_words(n_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int compares = 0;
  int fails    = 0;

  // write-port observer acting as the instruction memory
  logic [31:0] model [1024];
  int          wr_cnt = 0;
  int          last_addr = -1;
  bit          br_seen = 0;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      model[mem_addr] = mem_data;
      wr_cnt          = wr_cnt + 1;
      last_addr       = int'(mem_addr);
    end
    if (byte_ready) br_seen = 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All driving tasks start and end just after a rising edge.
  task automatic pulse_start(input logic [10:0] n);
    start   = 1'b1;
    n_words = n;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit sent = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 20 && !sent; i++) begin
      if (byte_ready) sent = 1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    if (!sent) check("byte_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(done), 64'(1));
  endtask

  task automatic clear_obs();
    wr_cnt    = 0;
    last_addr = -1;
    br_seen   = 0;
    model[0]  = '0;
    model[1]  = '0;
  endtask

  function automatic logic [7:0] stream_byte(input int i);
    return 8'(i * 7 + 3);
  endfunction

  typedef struct {
    logic [10:0] n;
    bit          gap;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          exp_err;
    int          exp_wr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{n: 11'd2,    gap: 0, w0: 32'h20080005, w1: 32'h3C01000A, exp_err: 0, exp_wr: 2};
    vecs[1] = '{n: 11'd2,    gap: 1, w0: 32'hAABBCCDD, w1: 32'h01234567, exp_err: 0, exp_wr: 2};
    vecs[2] = '{n: 11'd1025, gap: 0, w0: 32'h0,        w1: 32'h0,        exp_err: 1, exp_wr: 0};
    vecs[3] = '{n: 11'd1,    gap: 0, w0: 32'hDEADBEEF, w1: 32'h0,        exp_err: 0, exp_wr: 1};
    vecs[4] = '{n: 11'd0,    gap: 0, w0: 32'h0,        w1: 32'h0,        exp_err: 0, exp_wr: 0};
    vecs[5] = '{n: 11'd2047, gap: 0, w0: 32'h0,        w1: 32'h0,        exp_err: 1, exp_wr: 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 64'({byte_ready, mem_we, busy, done, err, mem_addr, mem_data}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      logic [31:0] w;
      clear_obs();
      pulse_start(vecs[v].n);
      check($sformatf("v%0d_busy_after_start", v), 64'({busy, done}), 64'(2'b10));
      if (vecs[v].n == 0) begin
        @(posedge clk); #1;
        check("v_n0_done_2cyc", 64'({busy, done}), 64'(2'b01));
      end
      if (!vecs[v].exp_err) begin
        for (int k = 0; k < int'(vecs[v].n); k++) begin
          w = (k == 0) ? vecs[v].w0 : vecs[v].w1;
          for (int b = 0; b < 4; b++) begin
            if (vecs[v].gap && k == 0 && b == 2) begin
              for (int g = 0; g < 3; g++) begin
                check($sformatf("v%0d_gap_ready%0d", v, g), 64'({byte_ready, mem_we}), 64'(2'b10));
                @(posedge clk); #1;
              end
            end
            send_byte(w[31 - 8*b -: 8]);
          end
          check($sformatf("v%0d_w%0d_we_latency", v, k), 64'(mem_we), 64'(1));
          check($sformatf("v%0d_w%0d_port", v, k), {22'(0), mem_addr, mem_data}, {22'(0), 10'(k), w});
        end
      end
      wait_done($sformatf("v%0d_done", v));
      check($sformatf("v%0d_busy_err", v), 64'({busy, err}), 64'({1'b0, vecs[v].exp_err}));
      check($sformatf("v%0d_wr_cnt", v), 64'(wr_cnt), 64'(vecs[v].exp_wr));
      if (vecs[v].n == 0) check("v_n0_no_ready", 64'(br_seen), 64'(0));
      if (vecs[v].exp_wr > 0) begin
        check($sformatf("v%0d_mem0", v), 64'(model[0]), 64'(vecs[v].w0));
        check($sformatf("v%0d_hold_addr", v), 64'(mem_addr), 64'(vecs[v].exp_wr - 1));
      end
      if (vecs[v].exp_wr > 1) check($sformatf("v%0d_mem1", v), 64'(model[1]), 64'(vecs[v].w1));
      @(posedge clk); #1;
    end

    // reset in the middle of the second word, then a fresh load
    clear_obs();
    pulse_start(11'd2);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hE1); send_byte(8'hE2);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({byte_ready, mem_we, busy, done, err, mem_addr, mem_data}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_obs();
    pulse_start(11'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("midrst_new_port", {22'(0), mem_we, mem_addr, mem_data}, {22'(0), 1'b1, 10'd0, 32'h11223344});
    wait_done("midrst_done");
    check("midrst_wr_cnt", 64'(wr_cnt), 64'(1));

    // start while busy is ignored: still two words, n_words not resampled
    clear_obs();
    pulse_start(11'd2);
    send_byte(8'hCA); send_byte(8'hFE);
    pulse_start(11'd1);
    check("busy_start_still_busy", 64'(busy), 64'(1));
    send_byte(8'hBA); send_byte(8'hBE);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    wait_done("busy_start_done");
    check("busy_start_wr_cnt", 64'(wr_cnt), 64'(2));
    check("busy_start_mem0", 64'(model[0]), 64'(32'hCAFEBABE));
    check("busy_start_mem1", 64'(model[1]), 64'(32'h55667788));

    // full memory: 1024 words, last write lands on 1023
    begin
      int bad = 0;
      logic [31:0] exp_w;
      clear_obs();
      pulse_start(11'd1024);
      for (int i = 0; i < 4096; i++) send_byte(stream_byte(i));
      wait_done("full_done");
      check("full_err", 64'(err), 64'(0));
      check("full_wr_cnt", 64'(wr_cnt), 64'(1024));
      check("full_last_addr", 64'(last_addr), 64'(1023));
      for (int k = 0; k < 1024; k++) begin
        exp_w = {stream_byte(4*k), stream_byte(4*k+1), stream_byte(4*k+2), stream_byte(4*k+3)};
        if (model[k] !== exp_w) bad++;
      end
      check("full_readback_bad_words", 64'(bad), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
